vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates the VGA raster timing that drives the pixel colour generators.
- Produces horizontal and vertical pixel counters, video_on, and the hsync/vsync pins.
- Also produces line and frame strobes.
- Sits between the 25 MHz pixel clock and every colour/pattern block. The colour blocks consume horizontal_num, vertical_num and video_on combinationally.

Parameters:
- HVID, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYNC, 96, horizontal sync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VVID, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk_25  input  1  pixel clock, 25 MHz
- reset  input  1  asynchronous, active-high reset
- en  input  1  pixel advance enable; tie high for free-running operation
- horizontal_num  output  10  current pixel column, 0..HTOTAL-1
- vertical_num  output  10  current line, 0..VTOTAL-1
- video_on  output  1  high when horizontal_num<HVID and vertical_num<VVID
- hsync  output  1  horizontal sync pin
- vsync  output  1  vertical sync pin
- line_start  output  1  one-cycle pulse when horizontal_num becomes 0
- frame_start  output  1  one-cycle pulse when both counters become 0
- frame_count  output  16  number of frames started since reset, wraps

Behaviour:
- Derived totals:
  - HTOTAL = HVID+HFP+HSYNC+HBP (800).
  - VTOTAL = VVID+VFP+VSYNC+VBP (525).
  - Elaboration error if HTOTAL>1024 or VTOTAL>1024.
- Interface: one clock, clk_25. reset is asynchronous and active-high. All outputs are flops on clk_25; there is no combinational path from inputs to outputs.
- Reset values:
  - horizontal_num=HTOTAL-1, vertical_num=VTOTAL-1.
  - video_on=0, hsync=vsync=!SYNC_POL (inactive).
  - line_start=frame_start=0, frame_count=0.
  - Rationale: the first enabled edge after reset lands on pixel (0,0) with frame_start=1.
- Advance: on a rising edge with en=1:
  - horizontal_num increments; at HTOTAL-1 it wraps to 0 and vertical_num increments.
  - vertical_num wraps from VTOTAL-1 to 0 only on a horizontal wrap.
  - With en=0 every output holds, and the strobes are forced to 0.
- Zero skew: video_on, hsync, vsync, line_start and frame_start are computed from the next counter values and registered on the same edge. They are therefore always consistent with the counters currently shown.
- hsync is active while HVID+HFP <= horizontal_num < HVID+HFP+HSYNC (656..751).
- vsync is active while VVID+VFP <= vertical_num < VVID+VFP+VSYNC (490..491). vsync changes only on a horizontal wrap edge.
- Strobes:
  - line_start is high for exactly one en-cycle per line.
  - frame_start is high for exactly one en-cycle per frame, coincident with line_start.
- frame_count increments on the edge that raises frame_start. It wraps 0xFFFF to 0 silently.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to their reset values. Timing restarts cleanly after release; no partial-frame memory is kept.
- en toggling mid-line: only position is frozen. Pulse widths are measured in enabled cycles.

Decomposition:
- Shared package vga_timing_pkg holds:
  - The 640x480@60 constants: HVID, HFP, HSYNC, HBP, VVID, VFP, VSYNC, VBP, HTOTAL, VTOTAL.
  - COUNT_W=10.
  - The sync polarity constant.
- Sub-module vga_axis_counter: parameterised wrap counter with inputs clk_25, reset, inc; outputs count, wrap and next_count. It is instantiated once for the horizontal axis and once for the vertical axis, with the vertical inc driven by the horizontal wrap.

Test Plan:
- Reset release, en=1: first edge gives (0,0), video_on=1, frame_start=1, line_start=1, frame_count=1. Second edge gives (1,0) with both strobes 0.
- Full line, en=1: hsync is low for exactly 96 cycles starting at horizontal_num=656. video_on is high for exactly 640 cycles per line on lines 0..479. The period is exactly 800 cycles.
- Full frame: vsync is low for exactly 2 lines (1600 cycles) starting at (0,490). frame_start pulses are 420000 cycles apart. video_on=0 throughout lines 480..524.
- Wrap corners: at (799,479) the next edge gives (0,480) with video_on=0. At (799,524) the next edge gives (0,0) with frame_start=1.
- en pattern 1-0-1 random: counters never skip or double-step. Outputs are frozen while en=0, and the strobes are 0 when en=0.
- Reset pulsed at (300,200): outputs go to the reset values without waiting for a clock edge. The first enabled edge after release gives (0,0) with frame_start=1 and frame_count=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants for the VGA sync generator.
// Holds the porch/sync widths, derived line/frame totals, counter width
// and the sync polarity used by vga_sync_gen and vga_axis_counter.
package vga_timing_pkg;

  localparam int HVID  = 640;
  localparam int HFP   = 16;
  localparam int HSYNC = 96;
  localparam int HBP   = 48;

  localparam int VVID  = 480;
  localparam int VFP   = 10;
  localparam int VSYNC = 2;
  localparam int VBP   = 33;

  localparam int HTOTAL = HVID + HFP + HSYNC + HBP;  // 800
  localparam int VTOTAL = VVID + VFP + VSYNC + VBP;  // 525

  localparam int COUNT_W = 10;

  // Active level of hsync/vsync: 0 means the pins pulse low.
  localparam logic SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while inc is high.
// Ports: clk_25/reset (async, active-high), inc in; count (registered),
// wrap (inc at TOTAL-1) and next_count (value after this edge) out.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = HTOTAL,
  parameter int W     = COUNT_W
) (
  input  logic         clk_25,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic [W-1:0] next_count
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    wrap    = inc && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  // Resetting to the last position makes the first advance land on 0.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign next_count = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, video_on, hsync/vsync, strobes.
// Ports: clk_25, reset (async, active-high), en (pixel advance) in;
// horizontal_num, vertical_num, video_on, hsync, vsync, line_start,
// frame_start, frame_count out -- all registered, no input-to-output path.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   HVID     = vga_timing_pkg::HVID,
  parameter int   HFP      = vga_timing_pkg::HFP,
  parameter int   HSYNC    = vga_timing_pkg::HSYNC,
  parameter int   HBP      = vga_timing_pkg::HBP,
  parameter int   VVID     = vga_timing_pkg::VVID,
  parameter int   VFP      = vga_timing_pkg::VFP,
  parameter int   VSYNC    = vga_timing_pkg::VSYNC,
  parameter int   VBP      = vga_timing_pkg::VBP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic               en,
  output logic [COUNT_W-1:0] horizontal_num,
  output logic [COUNT_W-1:0] vertical_num,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int H_TOT = HVID + HFP + HSYNC + HBP;
  localparam int V_TOT = VVID + VFP + VSYNC + VBP;

  if (H_TOT > (1 << COUNT_W)) begin : g_h_too_big
    $error("vga_sync_gen: horizontal total %0d exceeds counter range", H_TOT);
  end
  if (V_TOT > (1 << COUNT_W)) begin : g_v_too_big
    $error("vga_sync_gen: vertical total %0d exceeds counter range", V_TOT);
  end

  logic               h_wrap;
  logic               v_wrap;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;

  vga_axis_counter #(.TOTAL(H_TOT), .W(COUNT_W)) u_hcnt (
    .clk_25     (clk_25),
    .reset      (reset),
    .inc        (en),
    .count      (horizontal_num),
    .wrap       (h_wrap),
    .next_count (h_next)
  );

  // The vertical axis only moves when a line finishes.
  vga_axis_counter #(.TOTAL(V_TOT), .W(COUNT_W)) u_vcnt (
    .clk_25     (clk_25),
    .reset      (reset),
    .inc        (h_wrap),
    .count      (vertical_num),
    .wrap       (v_wrap),
    .next_count (v_next)
  );

  logic        video_on_q, video_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Decode from the next counter values so the registered flags line up
  // with the counters on the same edge (zero skew to the colour blocks).
  always_comb begin
    video_on_d = (int'(h_next) < HVID) && (int'(v_next) < VVID);

    hsync_d = ~SYNC_POL;
    if ((int'(h_next) >= HVID + HFP) && (int'(h_next) < HVID + HFP + HSYNC)) begin
      hsync_d = SYNC_POL;
    end

    vsync_d = ~SYNC_POL;
    if ((int'(v_next) >= VVID + VFP) && (int'(v_next) < VVID + VFP + VSYNC)) begin
      vsync_d = SYNC_POL;
    end

    // h_wrap already implies en, so the strobes drop to 0 when stalled.
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    frame_count_d = frame_count_q + {15'b0, frame_start_d};
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size 640x480 instance for reset, first edges
// and line timing; a shrunken instance (24x11) for frame-level corners,
// random enable stalls and asynchronous reset mid-frame.
module tb_vga_sync_gen;

  typedef struct {
    int   h;
    int   v;
    logic vid;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
    int   fc;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } geom_t;

  typedef struct {
    bit   en;
    obs_t exp;
  } vec_t;

  localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6,  SVF = 1, SVS = 2, SVB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst, d_en, s_rst, s_en;
  logic [9:0]  d_h, d_v, s_h, s_v;
  logic        d_vid, d_hs, d_vs, d_ls, d_fs;
  logic        s_vid, s_hs, s_vs, s_ls, s_fs;
  logic [15:0] d_fc, s_fc;

  vga_sync_gen u_d (
    .clk_25(clk), .reset(d_rst), .en(d_en),
    .horizontal_num(d_h), .vertical_num(d_v), .video_on(d_vid),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs),
    .frame_count(d_fc)
  );

  vga_sync_gen #(
    .HVID(SHV), .HFP(SHF), .HSYNC(SHS), .HBP(SHB),
    .VVID(SVV), .VFP(SVF), .VSYNC(SVS), .VBP(SVB), .SYNC_POL(1'b0)
  ) u_s (
    .clk_25(clk), .reset(s_rst), .en(s_en),
    .horizontal_num(s_h), .vertical_num(s_v), .video_on(s_vid),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs),
    .frame_count(s_fc)
  );

  int    errors = 0;
  int    checks = 0;
  geom_t dg, sg;
  int    d_p, d_fcm, s_p, s_fcm;   // model: linear pixel index + frame count
  obs_t  sb[$];

  function automatic int ht_of(geom_t g); return g.hv + g.hf + g.hs + g.hb; endfunction
  function automatic int vt_of(geom_t g); return g.vv + g.vf + g.vs + g.vb; endfunction

  // Expected outputs for linear pixel position p; moved = an enabled edge.
  function automatic obs_t expect_at(geom_t g, int p, int fc, bit moved);
    obs_t e;
    int ht = ht_of(g);
    e.h   = p % ht;
    e.v   = p / ht;
    e.vid = (e.h < g.hv) && (e.v < g.vv);
    e.hs  = !((e.h >= g.hv + g.hf) && (e.h < g.hv + g.hf + g.hs));
    e.vs  = !((e.v >= g.vv + g.vf) && (e.v < g.vv + g.vf + g.vs));
    e.ls  = moved && (e.h == 0);
    e.fs  = moved && (p == 0);
    e.fc  = fc;
    return e;
  endfunction

  function automatic obs_t get_d();
    obs_t a;
    a.h = int'(d_h); a.v = int'(d_v); a.vid = d_vid; a.hs = d_hs; a.vs = d_vs;
    a.ls = d_ls; a.fs = d_fs; a.fc = int'(d_fc);
    return a;
  endfunction

  function automatic obs_t get_s();
    obs_t a;
    a.h = int'(s_h); a.v = int'(s_v); a.vid = s_vid; a.hs = s_hs; a.vs = s_vs;
    a.ls = s_ls; a.fs = s_fs; a.fc = int'(s_fc);
    return a;
  endfunction

  task automatic check_obs(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a.h != e.h || a.v != e.v || a.vid !== e.vid || a.hs !== e.hs ||
        a.vs !== e.vs || a.ls !== e.ls || a.fs !== e.fs || a.fc != e.fc) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d vid=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d vid=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               nm, a.h, a.v, a.vid, a.hs, a.vs, a.ls, a.fs, a.fc,
               e.h, e.v, e.vid, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock on the full-size instance; the small instance holds.
  task automatic step_d(input bit e);
    obs_t ex;
    d_en = e; s_en = 1'b0;
    if (e) begin
      d_p = (d_p + 1) % (ht_of(dg) * vt_of(dg));
      if (d_p == 0) d_fcm = (d_fcm + 1) % 65536;
    end
    sb.push_back(expect_at(dg, d_p, d_fcm, e));
    @(posedge clk); #1;
    ex = sb.pop_front();
    check_obs("d_step", get_d(), ex);
  endtask

  task automatic step_s(input bit e);
    obs_t ex;
    s_en = e; d_en = 1'b0;
    if (e) begin
      s_p = (s_p + 1) % (ht_of(sg) * vt_of(sg));
      if (s_p == 0) s_fcm = (s_fcm + 1) % 65536;
    end
    sb.push_back(expect_at(sg, s_p, s_fcm, e));
    @(posedge clk); #1;
    ex = sb.pop_front();
    check_obs("s_step", get_s(), ex);
  endtask

  initial begin
    vec_t vecs[6];
    obs_t rst_d, rst_s;
    int   hs_cnt, hs_first, vid_cnt, last_ls;
    int   vs_cnt, fs_gap, fs_seen;
    logic prev_vs;
    bit   e;

    dg = '{640, 16, 96, 48, 480, 10, 2, 33};
    sg = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB};

    // Reset-release walk on the full-size instance: two advances, a
    // two-cycle stall (position held, strobes low), then two more.
    vecs[0] = '{1'b1, '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1}};
    vecs[1] = '{1'b1, '{1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};
    vecs[2] = '{1'b0, '{1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};
    vecs[3] = '{1'b0, '{1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};
    vecs[4] = '{1'b1, '{2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};
    vecs[5] = '{1'b1, '{3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};

    rst_d = '{799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    rst_s = '{23, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};

    d_rst = 1'b1; s_rst = 1'b1; d_en = 1'b1; s_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_obs("reset_d", get_d(), rst_d);
    check_obs("reset_s", get_s(), rst_s);
    d_rst = 1'b0; s_rst = 1'b0; d_en = 1'b0; s_en = 1'b0;
    d_p = ht_of(dg) * vt_of(dg) - 1; d_fcm = 0;
    s_p = ht_of(sg) * vt_of(sg) - 1; s_fcm = 0;
    @(posedge clk); #1;   // released, en low: nothing moves
    check_obs("hold_after_reset", get_d(), rst_d);

    for (int i = 0; i < 6; i++) begin
      d_en = vecs[i].en; s_en = 1'b0;
      @(posedge clk); #1;
      check_obs($sformatf("vec%0d", i), get_d(), vecs[i].exp);
    end
    d_p = 3; d_fcm = 1;

    // Full-size line timing, measured on line 1.
    hs_cnt = 0; hs_first = -1; vid_cnt = 0; last_ls = -1;
    for (int i = 0; i < 2400; i++) begin
      step_d(1'b1);
      if (d_v == 10'd1) begin
        if (!d_hs) begin
          if (hs_first < 0) hs_first = int'(d_h);
          hs_cnt++;
        end
        if (d_vid) vid_cnt++;
      end
      if (d_ls) begin
        if (last_ls >= 0) check_int("line_period", i - last_ls, 800);
        last_ls = i;
      end
    end
    check_int("hsync_width", hs_cnt, 96);
    check_int("hsync_start", hs_first, 656);
    check_int("video_per_line", vid_cnt, 640);

    // Small instance: random enable stalls across several frames.
    vs_cnt = 0; fs_gap = 0; fs_seen = 0; prev_vs = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      e = ($urandom_range(0, 2) != 0);
      step_s(e);
      if (e) begin
        if (s_fs) begin
          if (fs_seen != 0) begin
            check_int("frame_period", fs_gap, 264);
            check_int("vsync_width", vs_cnt, 48);
          end
          fs_seen = 1; fs_gap = 0; vs_cnt = 0;
        end
        fs_gap++;
        if (!s_vs) vs_cnt++;
        if (prev_vs && !s_vs) check_int("vsync_start", int'(s_v) * 24 + int'(s_h), 7 * 24);
        prev_vs = s_vs;
      end
    end
    check_int("frames_seen", (s_fcm >= 2) ? 1 : 0, 1);

    // Asynchronous reset mid-frame at (10,4).
    while (s_p != 4 * 24 + 10) step_s(1'b1);
    s_en = 1'b0;
    @(posedge clk); #2;
    s_rst = 1'b1;
    #1;
    check_obs("async_reset", get_s(), rst_s);
    @(posedge clk); #1;
    s_rst = 1'b0;
    s_p = ht_of(sg) * vt_of(sg) - 1; s_fcm = 0;
    step_s(1'b1);
    check_obs("restart", get_s(), '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1});
    step_s(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
